// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses,
// mstatus field positions, default widths and the sequencer state encoding.
package trap_sequencer_pkg;

   localparam int XLEN_DEF = 32;
   localparam int EX_W_DEF = 5;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_SAVE_EPC    = 3'd1,
      ST_SAVE_CAUSE  = 3'd2,
      ST_SAVE_TVAL   = 3'd3,
      ST_UPD_STATUS  = 3'd4,
      ST_MRET_STATUS = 3'd5,
      ST_REDIRECT    = 3'd6
   } state_t;

endpackage

// File: rtl/trap_sequencer_vector_calc.sv
// Combinational redirect target: mepc for MRET, otherwise the mtvec base,
// offset by 4*cause only for interrupts in vectored mode (mode 01).
module trap_vector_calc
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int EX_W = EX_W_DEF
) (
   input  logic [XLEN-1:0] i_mtvec,
   input  logic [EX_W-1:0] i_cause,
   input  logic            i_is_mret,
   input  logic [XLEN-1:0] i_mepc,
   output logic [XLEN-1:0] o_pc
);

   logic [XLEN-1:0] w_base;
   logic [XLEN-1:0] w_offset;
   logic            w_vectored;

   assign w_base     = i_mtvec & {{(XLEN-2){1'b1}}, 2'b00};
   assign w_vectored = (i_mtvec[1:0] == 2'b01) && i_cause[EX_W-1];
   assign w_offset   = {{(XLEN-EX_W-1){1'b0}}, i_cause[EX_W-2:0], 2'b00};

   always_comb begin
      o_pc = w_base;
      if (i_is_mret) begin
         o_pc = i_mepc;
      end else if (w_vectored) begin
         o_pc = w_base + w_offset;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences trap entry (mepc, mcause, mtval, mstatus writes) and MRET return
// through a single CSR write port, then pulses a one-cycle PC redirect.
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int EX_W = EX_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            exception_valid,
   input  logic [EX_W-1:0] exception,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_tval,
   input  logic            mret_valid,
   input  logic [XLEN-1:0] mtvec_in,
   input  logic [XLEN-1:0] mepc_in,
   input  logic [XLEN-1:0] mstatus_in,
   output logic            csr_wr_en,
   output logic [11:0]     csr_wr_addr,
   output logic [XLEN-1:0] csr_wr_data,
   output logic            stall,
   output logic            flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   state_t          r_state;
   state_t          w_state_next;

   logic [XLEN-1:0] r_pc,      w_pc_next;
   logic [XLEN-1:0] r_tval,    w_tval_next;
   logic [XLEN-1:0] r_mtvec,   w_mtvec_next;
   logic [XLEN-1:0] r_mstatus, w_mstatus_next;
   logic [XLEN-1:0] r_mepc,    w_mepc_next;
   logic [EX_W-1:0] r_cause,   w_cause_next;
   logic            r_is_mret, w_is_mret_next;

   logic            r_csr_wr_en,   w_csr_wr_en_next;
   logic [11:0]     r_csr_wr_addr, w_csr_wr_addr_next;
   logic [XLEN-1:0] r_csr_wr_data, w_csr_wr_data_next;
   logic            r_redirect_valid;
   logic [XLEN-1:0] r_redirect_pc;

   logic            w_idle;
   logic            w_accept_trap;
   logic            w_accept_mret;
   logic [XLEN-1:0] w_mcause_next;
   logic [XLEN-1:0] w_target_pc;

   function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] m);
      logic [XLEN-1:0] s;
      s = m;
      s[MSTATUS_MPIE] = m[MSTATUS_MIE];
      s[MSTATUS_MIE]  = 1'b0;
      s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return s;
   endfunction

   function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] m);
      logic [XLEN-1:0] s;
      s = m;
      s[MSTATUS_MIE]  = m[MSTATUS_MPIE];
      s[MSTATUS_MPIE] = 1'b1;
      s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return s;
   endfunction

   // Exception has priority: a simultaneous MRET is dropped.
   assign w_idle        = (r_state == ST_IDLE);
   assign w_accept_trap = w_idle && exception_valid;
   assign w_accept_mret = w_idle && mret_valid && !exception_valid;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept_trap) begin
               w_state_next = ST_SAVE_EPC;
            end else if (w_accept_mret) begin
               w_state_next = ST_MRET_STATUS;
            end
         end
         ST_SAVE_EPC:    w_state_next = ST_SAVE_CAUSE;
         ST_SAVE_CAUSE:  w_state_next = ST_SAVE_TVAL;
         ST_SAVE_TVAL:   w_state_next = ST_UPD_STATUS;
         ST_UPD_STATUS:  w_state_next = ST_REDIRECT;
         ST_MRET_STATUS: w_state_next = ST_REDIRECT;
         ST_REDIRECT:    w_state_next = ST_IDLE;
         default:        w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pc_next      = w_accept_trap ? ex_pc      : r_pc;
      w_tval_next    = w_accept_trap ? ex_tval    : r_tval;
      w_mtvec_next   = w_accept_trap ? mtvec_in   : r_mtvec;
      w_cause_next   = w_accept_trap ? exception  : r_cause;
      w_mepc_next    = w_accept_mret ? mepc_in    : r_mepc;
      w_mstatus_next = (w_accept_trap || w_accept_mret) ? mstatus_in : r_mstatus;
      w_is_mret_next = r_is_mret;
      if (w_accept_trap) begin
         w_is_mret_next = 1'b0;
      end else if (w_accept_mret) begin
         w_is_mret_next = 1'b1;
      end
   end

   always_comb begin
      w_mcause_next = '0;
      w_mcause_next[XLEN-1]   = w_cause_next[EX_W-1];
      w_mcause_next[EX_W-2:0] = w_cause_next[EX_W-2:0];
   end

   // CSR port outputs are registered, so they are decoded from the state being entered.
   always_comb begin
      w_csr_wr_en_next   = 1'b0;
      w_csr_wr_addr_next = '0;
      w_csr_wr_data_next = '0;
      unique case (w_state_next)
         ST_SAVE_EPC: begin
            w_csr_wr_en_next   = 1'b1;
            w_csr_wr_addr_next = CSR_MEPC;
            w_csr_wr_data_next = w_pc_next & {{(XLEN-2){1'b1}}, 2'b00};
         end
         ST_SAVE_CAUSE: begin
            w_csr_wr_en_next   = 1'b1;
            w_csr_wr_addr_next = CSR_MCAUSE;
            w_csr_wr_data_next = w_mcause_next;
         end
         ST_SAVE_TVAL: begin
            w_csr_wr_en_next   = 1'b1;
            w_csr_wr_addr_next = CSR_MTVAL;
            w_csr_wr_data_next = w_tval_next;
         end
         ST_UPD_STATUS: begin
            w_csr_wr_en_next   = 1'b1;
            w_csr_wr_addr_next = CSR_MSTATUS;
            w_csr_wr_data_next = trap_status(w_mstatus_next);
         end
         ST_MRET_STATUS: begin
            w_csr_wr_en_next   = 1'b1;
            w_csr_wr_addr_next = CSR_MSTATUS;
            w_csr_wr_data_next = mret_status(w_mstatus_next);
         end
         default: begin
         end
      endcase
   end

   trap_vector_calc #(
      .XLEN (XLEN),
      .EX_W (EX_W)
   ) u_vector_calc (
      .i_mtvec   (w_mtvec_next),
      .i_cause   (w_cause_next),
      .i_is_mret (w_is_mret_next),
      .i_mepc    (w_mepc_next),
      .o_pc      (w_target_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= ST_IDLE;
         r_pc             <= '0;
         r_tval           <= '0;
         r_mtvec          <= '0;
         r_mstatus        <= '0;
         r_mepc           <= '0;
         r_cause          <= '0;
         r_is_mret        <= 1'b0;
         r_csr_wr_en      <= 1'b0;
         r_csr_wr_addr    <= '0;
         r_csr_wr_data    <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_state          <= w_state_next;
         r_pc             <= w_pc_next;
         r_tval           <= w_tval_next;
         r_mtvec          <= w_mtvec_next;
         r_mstatus        <= w_mstatus_next;
         r_mepc           <= w_mepc_next;
         r_cause          <= w_cause_next;
         r_is_mret        <= w_is_mret_next;
         r_csr_wr_en      <= w_csr_wr_en_next;
         r_csr_wr_addr    <= w_csr_wr_addr_next;
         r_csr_wr_data    <= w_csr_wr_data_next;
         r_redirect_valid <= (w_state_next == ST_REDIRECT);
         if (w_state_next == ST_REDIRECT) begin
            r_redirect_pc <= w_target_pc;
         end
      end
   end

   assign csr_wr_en      = r_csr_wr_en;
   assign csr_wr_addr    = r_csr_wr_addr;
   assign csr_wr_data    = r_csr_wr_data;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign busy           = !w_idle;
   // Stall and flush rise combinationally in the accept cycle.
   assign stall          = busy || (w_idle && (exception_valid || mret_valid));
   assign flush          = stall;

endmodule
